// File: rtl/rr_fifo_arbiter_pkg.sv
// Shared types and helpers for the round-robin fifo arbiter and its pick logic.
package rr_fifo_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Bits needed to count 0..max_burst inclusive.
    function automatic int unsigned burst_width(input int unsigned max_burst);
        return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/rr_fifo_arbiter_pick.sv
// Rotating priority picker: first set req bit at or after start, wrapping modulo N.
module rr_pick #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [N-1:0] rot;
    logic [W-1:0] pos;

    // Rotate so that bit 0 of rot is req[start].
    always_comb begin
        rot = '0;
        for (int unsigned k = 0; k < N; k++) begin
            for (int unsigned j = 0; j < N; j++) begin
                if (((32'(start) + k) % N) == j) begin
                    rot[k] = req[j];
                end
            end
        end
    end

    // Priority-encode the lowest set bit, then un-rotate back to an input index.
    always_comb begin
        found = |rot;
        pos   = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            if (rot[k]) begin
                pos = W'(k);
            end
        end
        idx = W'((32'(start) + 32'(pos)) % N);
    end

endmodule

// File: rtl/rr_fifo_arbiter.sv
// Round-robin, burst-bounded arbiter popping N_INPUTS fifos into one registered output.
// Optional pop/stall tracing is compiled in with RR_ARB_TRACE_EN.
module rr_fifo_arbiter
    import rr_fifo_arbiter_pkg::*;
#(
    parameter int          ID               = -1,
    parameter int unsigned N_INPUTS         = 4,
    parameter int unsigned SIZE             = 8,
    parameter int unsigned DESTINATION_BITS = 4,
    parameter int unsigned SEL_BITS         = 2,
    parameter int unsigned MAX_BURST        = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_INPUTS-1:0]      fifo_empty,
    input  logic [N_INPUTS*SIZE-1:0] fifo_items,
    output logic [N_INPUTS-1:0]      fifo_read,
    output logic [SIZE-1:0]          out_item,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SEL_BITS-1:0]      grant_id
);

    localparam int unsigned          BURST_BITS = burst_width(MAX_BURST);
    localparam logic [SEL_BITS-1:0]  LAST_IDX   = SEL_BITS'(N_INPUTS - 1);
    localparam logic [BURST_BITS-1:0] BURST_MAX = BURST_BITS'(MAX_BURST);

    arb_state_e            state_q, state_d;
    logic [SEL_BITS-1:0]   last_grant_q, last_grant_d;
    logic [BURST_BITS-1:0] burst_cnt_q, burst_cnt_d;
    logic [SIZE-1:0]       item_d;
    logic                  valid_d;
    logic [SEL_BITS-1:0]   grant_d;

    logic [N_INPUTS-1:0]   req;
    logic                  can_load;
    logic                  stay;
    logic                  pop;
    logic [SEL_BITS-1:0]   pick_start;
    logic                  pick_found;
    logic [SEL_BITS-1:0]   pick_idx;
    logic [SEL_BITS-1:0]   sel;
    logic [SIZE-1:0]       head_item;

    // Rotation begins just after the last grant so the last grant is searched last.
    always_comb begin
        req        = ~fifo_empty;
        can_load   = !out_valid || out_ready;
        stay       = (state_q == ARB_BUSY) && (burst_cnt_q < BURST_MAX) && req[last_grant_q];
        pick_start = (last_grant_q == LAST_IDX) ? '0 : last_grant_q + SEL_BITS'(1);
    end

    rr_pick #(
        .N (N_INPUTS),
        .W (SEL_BITS)
    ) u_pick (
        .req   (req),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        sel       = stay ? last_grant_q : pick_idx;
        pop       = can_load && pick_found;
        head_item = '0;
        for (int unsigned i = 0; i < N_INPUTS; i++) begin
            if (SEL_BITS'(i) == sel) begin
                head_item = fifo_items[i*SIZE +: SIZE];
            end
        end
    end

    // Pop strobe is combinational; held off while reset is asserted.
    assign fifo_read = (reset && pop) ? (N_INPUTS'(1) << sel) : '0;

    // Next-state and datapath updates.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        item_d       = out_item;
        valid_d      = out_valid;
        grant_d      = grant_id;

        case (state_q)
            ARB_IDLE: begin
                if (pop) begin
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (!pop && out_ready) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        if (pop) begin
            item_d       = head_item;
            valid_d      = 1'b1;
            grant_d      = sel;
            last_grant_d = sel;
            if ((sel == last_grant_q) && (state_q == ARB_BUSY)) begin
                burst_cnt_d = (burst_cnt_q == BURST_MAX) ? burst_cnt_q
                                                         : burst_cnt_q + BURST_BITS'(1);
            end else begin
                burst_cnt_d = BURST_BITS'(1);
            end
        end else if (out_valid && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= LAST_IDX;
            burst_cnt_q  <= '0;
            out_item     <= '0;
            out_valid    <= 1'b0;
            grant_id     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
            out_item     <= item_d;
            out_valid    <= valid_d;
            grant_id     <= grant_d;
        end
    end

`ifdef RR_ARB_TRACE_EN
    // Trace fields split the item as payload above DESTINATION_BITS, dest below.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (pop) begin
                $display("ARB(%0d): granted %0h:%0h from input %0d (burst = %0d)", ID,
                         head_item[DESTINATION_BITS-1:0], head_item[SIZE-1:DESTINATION_BITS],
                         sel, burst_cnt_d);
            end else if (out_valid && !out_ready) begin
                $display("ARB(%0d): stalled", ID);
            end
        end
    end
`else
    logic unused_trace_cfg;
    assign unused_trace_cfg = ^{32'(ID), 32'(DESTINATION_BITS)};
`endif

endmodule

// File: tb/tb_rr_fifo_arbiter.sv
// Randomized directed bench for rr_fifo_arbiter against a queue-based reference model.
module tb_rr_fifo_arbiter;

    localparam int N    = 4;
    localparam int SIZE = 8;
    localparam int MAXB = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      fifo_empty;
    logic [N*SIZE-1:0] fifo_items;
    logic [N-1:0]      fifo_read;
    logic [SIZE-1:0]   out_item;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        grant_id;

    int checks = 0;
    int errors = 0;

    // Fifo contents and the expected arbiter state.
    logic [SIZE-1:0] q [N][$];
    int              m_last;
    int              m_burst;
    int              m_grant;
    logic            m_valid;
    logic [SIZE-1:0] m_item;

    always #5 clk = ~clk;

    rr_fifo_arbiter #(
        .ID               (0),
        .N_INPUTS         (N),
        .SIZE             (SIZE),
        .DESTINATION_BITS (4),
        .SEL_BITS         (2),
        .MAX_BURST        (MAXB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_items (fifo_items),
        .fifo_read  (fifo_read),
        .out_item   (out_item),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .grant_id   (grant_id)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last  = N - 1;
        m_burst = 0;
        m_grant = 0;
        m_valid = 1'b0;
        m_item  = '0;
    endtask

    task automatic drive_fifos();
        for (int i = 0; i < N; i++) begin
            fifo_empty[i] = (q[i].size() == 0);
            fifo_items[i*SIZE +: SIZE] = (q[i].size() != 0) ? q[i][0] : SIZE'($urandom);
        end
    endtask

    // Stay on the last grant while its burst budget lasts, else the next requester in ring order.
    function automatic int model_pick();
        if (m_valid && m_burst < MAXB && q[m_last].size() > 0) return m_last;
        for (int k = 1; k <= N; k++) begin
            if (q[(m_last + k) % N].size() > 0) return (m_last + k) % N;
        end
        return -1;
    endfunction

    function automatic bit any_pending();
        for (int i = 0; i < N; i++) if (q[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push(input int i, input logic [SIZE-1:0] v);
        q[i].push_back(v);
    endtask

    // One clock: drive, check the pop strobe, clock, then check the registered outputs.
    task automatic cycle(input logic rdy);
        int   pick;
        logic pop;
        out_ready = rdy;
        drive_fifos();
        #1;
        pick = model_pick();
        pop  = (!m_valid || rdy) && (pick >= 0);
        check("fifo_read", 32'(fifo_read), pop ? (32'd1 << pick) : 32'd0);
        @(posedge clk);
        if (pop) begin
            m_item  = q[pick].pop_front();
            m_burst = (pick == m_last && m_valid) ? ((m_burst < MAXB) ? m_burst + 1 : MAXB) : 1;
            m_last  = pick;
            m_grant = pick;
            m_valid = 1'b1;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_item", 32'(out_item), 32'(m_item));
        check("grant_id", 32'(grant_id), 32'(m_grant));
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && (m_valid || any_pending()); n++) cycle(1'b1);
        check("drain_idle", 32'(out_valid), 32'd0);
    endtask

    initial begin
        reset      = 1'b0;
        out_ready  = 1'b1;
        fifo_empty = '1;
        fifo_items = '0;
        model_reset();

        // Reset with a single requester on input 2.
        push(2, 8'hA5);
        #2;
        drive_fifos();
        #1;
        check("rst_fifo_read", 32'(fifo_read), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_item", 32'(out_item), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold_read", 32'(fifo_read), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b1);
        check("first_grant", 32'(grant_id), 32'd2);
        drain();

        // Full contention.
        for (int i = 0; i < N; i++) for (int k = 0; k < 6; k++) push(i, SIZE'($urandom));
        for (int c = 0; c < 12; c++) cycle(1'b1);
        drain();

        // Bursts between inputs 1 and 3, then input 1 running dry after one item.
        for (int k = 0; k < 3; k++) begin
            push(1, SIZE'($urandom));
            push(3, SIZE'($urandom));
        end
        for (int c = 0; c < 6; c++) cycle(1'b1);
        drain();
        push(1, 8'h11);
        for (int k = 0; k < 3; k++) push(3, SIZE'($urandom));
        cycle(1'b1);
        cycle(1'b1);
        check("burst_rotate", 32'(grant_id), 32'd3);
        drain();

        // Backpressure for three cycles, then release.
        for (int k = 0; k < 2; k++) begin
            push(0, SIZE'($urandom));
            push(2, SIZE'($urandom));
        end
        cycle(1'b1);
        for (int c = 0; c < 3; c++) cycle(1'b0);
        cycle(1'b1);
        cycle(1'b1);
        drain();

        // Idle then a fresh push to input 0.
        cycle(1'b1);
        push(0, 8'h3C);
        cycle(1'b1);
        check("idle_wake_item", 32'(out_item), 32'h3C);
        drain();

        // Random traffic and backpressure.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0 && q[i].size() < 8) push(i, SIZE'($urandom));
            end
            cycle($urandom_range(0, 3) != 0);
        end
        drain();

        // Asynchronous reset between edges while busy.
        for (int i = 0; i < N; i++) for (int k = 0; k < 4; k++) push(i, SIZE'($urandom));
        for (int c = 0; c < 3; c++) cycle(1'b1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("async_valid", 32'(out_valid), 32'd0);
        check("async_read", 32'(fifo_read), 32'd0);
        check("async_item", 32'(out_item), 32'd0);
        model_reset();
        for (int i = 0; i < N; i++) q[i].delete();
        push(1, 8'h5A);
        push(3, 8'hC3);
        drive_fifos();
        #1;
        check("async_hold_read", 32'(fifo_read), 32'd0);
        @(posedge clk);
        #1;
        check("async_hold_valid", 32'(out_valid), 32'd0);
        check("async_hold_read2", 32'(fifo_read), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b1);
        check("post_reset_grant", 32'(grant_id), 32'd1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
